// File: rtl/axi4_mm_read_burst_master.sv
// AXI4 read master: splits one read command into AR bursts capped by MAX_BURST and the 4 KB
// boundary, and forwards R beats onto a valid/ready stream with an end-of-command flag.
module axi4_mm_read_burst_master #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ID_VAL    = 0
) (
    input  logic              aclk_i,
    input  logic              areset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_beats_i,
    input  logic              cmd_fixed_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ID_W-1:0]   arid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [ID_W-1:0]   rid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        err_code_o
);

    localparam int unsigned Bpb    = DATA_W / 8;
    localparam int unsigned Size   = $clog2(Bpb);
    localparam int unsigned FixCap = (MAX_BURST < 16) ? MAX_BURST : 16;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              fixed_q, fixed_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [7:0]        beat_q, beat_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;

    logic [12:0] bnd_beats;
    logic [31:0] beats_c;
    logic [7:0]  burst_len;
    logic [8:0]  nbeats;
    logic        xfer;
    logic        last_in_burst;
    logic        proto;

    // Burst size only depends on registers, so it is stable while AR waits for arready.
    always_comb begin
        bnd_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> Size;
        beats_c   = 32'(rem_q);
        if (fixed_q) begin
            if (FixCap < beats_c) beats_c = FixCap;
        end else begin
            if (MAX_BURST < beats_c) beats_c = MAX_BURST;
            if (32'(bnd_beats) < beats_c) beats_c = 32'(bnd_beats);
        end
        burst_len = 8'(beats_c - 32'd1);
    end

    assign nbeats        = {1'b0, arlen_q} + 9'd1;
    assign xfer          = (state_q == StData) && rvalid_i && m_ready_i;
    assign last_in_burst = (beat_q == arlen_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        fixed_d = fixed_q;
        arlen_d = arlen_q;
        beat_d  = beat_q;
        err_d   = err_q;
        code_d  = code_q;
        proto   = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d  = (cmd_addr_i >> Size) << Size;
                    rem_d   = cmd_beats_i;
                    fixed_d = cmd_fixed_i;
                    err_d   = 1'b0;
                    code_d  = 3'b000;
                    state_d = (cmd_beats_i == '0) ? StDone : StAddr;
                end
            end
            StAddr: begin
                if (arready_i) begin
                    arlen_d = burst_len;
                    beat_d  = 8'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (xfer) begin
                    beat_d = beat_q + 8'd1;
                    rem_d  = rem_q - LEN_W'(1);
                    proto  = (rlast_i != last_in_burst) || (rid_i != ID_W'(ID_VAL));
                    if ((rresp_i != 2'b00) || proto) begin
                        err_d = 1'b1;
                        if (!err_q) code_d = {proto, rresp_i};
                    end
                    // The beat counter, not rlast, closes the burst.
                    if (last_in_burst) begin
                        if (!fixed_q) addr_d = addr_q + (ADDR_W'(nbeats) << Size);
                        state_d = (rem_q == LEN_W'(1)) ? StDone : StAddr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            fixed_q <= 1'b0;
            arlen_q <= 8'd0;
            beat_q  <= 8'd0;
            err_q   <= 1'b0;
            code_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            fixed_q <= fixed_d;
            arlen_q <= arlen_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign arvalid_o   = (state_q == StAddr);
    assign arid_o      = ID_W'(ID_VAL);
    assign araddr_o    = addr_q;
    assign arlen_o     = (state_q == StAddr) ? burst_len : arlen_q;
    assign arsize_o    = 3'(Size);
    assign arburst_o   = fixed_q ? 2'b00 : 2'b01;
    assign rready_o    = (state_q == StData) && m_ready_i;
    assign m_valid_o   = (state_q == StData) && rvalid_i;
    assign m_data_o    = rdata_i;
    assign m_last_o    = (state_q == StData) && (rem_q == LEN_W'(1));
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign err_o       = err_q;
    assign err_code_o  = code_q;

endmodule
